multicycle_control: RTL and testbench

//  Multicycle CPU control FSM: the initiator of the ALU interface. Decodes the instruction

---
 rtl/multicycle_control.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Control FSM of a multicycle CPU. Decodes the instruction register, steps
//   through FETCH..WRITEBACK and drives the ALU operation code plus all
//   datapath selects and enables. Memory accesses use a req/ack handshake, so
//   every access may take any number of cycles.
//
// Memory handshake: mem_req (with mem_we and iord) is raised by the FSM and
//   held unchanged until the cycle in which mem_ack is sampled high; that cycle
//   completes the access and the FSM advances on the following edge. mem_ack
//   while mem_req is low is ignored. An ack in the first request cycle gives a
//   single-cycle access.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   instr[n-1:0]     IR contents (opcode = [31:26], funct = [5:0])
//   zero             ALU zero flag (consumed by the datapath via pc_write_cond)
//   mem_ack          memory completes the current request this cycle
//   mem_req/mem_we   memory request / write qualifier
//   iord             memory address select: 0 = PC, 1 = ALUOut
//   ir_write         load instruction register
//   pc_write         unconditional PC load
//   pc_write_cond    PC load when zero is set
//   pc_src[1:0]      00 = ALU, 01 = ALUOut, 10 = jump target
//   alu_src_a        0 = PC, 1 = rs
//   alu_src_b[1:0]   00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//   aluControl[3:0]  ALU operation code
//   reg_write        register file write
//   reg_dst          0 = rt, 1 = rd
//   mem_to_reg       0 = ALUOut, 1 = MDR
//   illegal          sticky trap flag for unsupported opcode/funct
//   retired          count of completed instructions (wraps)
//   dbg_state[3:0]   current FSM state, for observation only
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int n      = 32,
    parameter int RETIRE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [n-1:0]      instr,
    input  logic              zero,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic              iord,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic [1:0]        pc_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [3:0]        aluControl,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              illegal,
    output logic [RETIRE-1:0] retired,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_MEMWB  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_NAND = 4'b1000;
    localparam logic [3:0] ALU_NOT  = 4'b1001;
    localparam logic [3:0] ALU_JR   = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SGT  = 4'b1100;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_JR   = 6'b001000;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_illegal;
    logic [RETIRE-1:0] r_retired;

    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic              w_funct_legal;
    logic [3:0]        w_funct_alu;
    logic              w_retire;
    logic              w_unused;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];

    // zero only matters to the datapath (through pc_write_cond); the IR
    // fields outside opcode/funct are register numbers and immediates.
    assign w_unused = ^{zero, instr};

    // R-type funct decode: legality plus the ALU code used in EXEC.
    always_comb begin
        w_funct_legal = 1'b1;
        w_funct_alu   = ALU_ADD;
        case (w_funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b100110: w_funct_alu = ALU_XOR;
            6'b100111: w_funct_alu = ALU_NOR;
            6'b101000: w_funct_alu = ALU_NAND;
            6'b101001: w_funct_alu = ALU_NOT;
            6'b101010: w_funct_alu = ALU_SLT;
            6'b101011: w_funct_alu = ALU_SGT;
            6'b000000: w_funct_alu = ALU_SLL;
            6'b000010: w_funct_alu = ALU_SRL;
            FN_JR:     w_funct_alu = ALU_JR;
            default: begin
                w_funct_legal = 1'b0;
                w_funct_alu   = ALU_ADD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  if (mem_ack) w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = w_funct_legal ? S_EXEC : S_TRAP;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR: w_next_state = (w_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ack) w_next_state = S_MEMWB;
            S_MEMWR:  if (mem_ack) w_next_state = S_FETCH;
            S_MEMWB:  w_next_state = S_FETCH;
            S_EXEC:   w_next_state = (w_funct == FN_JR) ? S_FETCH : S_ALUWB;
            S_ALUWB:  w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_ADDIWB: w_next_state = S_FETCH;
            S_JUMP:   w_next_state = S_FETCH;
            S_TRAP:   w_next_state = S_TRAP;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Every instruction ends by returning to FETCH; TRAP never does.
    assign w_retire = (r_state != S_FETCH) && (w_next_state == S_FETCH);

    // Sticky trap flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            if (r_state == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + RETIRE'(1);
            end
        end
    end

    // Output decode. Everything is forced low while reset is asserted so an
    // in-flight memory request is withdrawn immediately, not at the next edge.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        aluControl    = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    // IR and PC+4 load in the cycle the fetch completes.
                    if (mem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a  = 1'b1;
                    aluControl = w_funct_alu;
                    if (w_funct == FN_JR) begin
                        pc_write = 1'b1;
                    end
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    aluControl    = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign illegal   = r_illegal;
    assign retired   = r_retired;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWR  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  aluControl;
    logic        reg_write, reg_dst, mem_to_reg, illegal;
    logic [15:0] retired;
    logic [3:0]  dbg_state;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_retired = '0;

    // funct -> expected ALU code, taken from the ISA tables
    logic [5:0] fn_tab [11] = '{6'b101011, 6'b101001, 6'b100010, 6'b101010,
                                6'b000000, 6'b000010, 6'b101000, 6'b100100,
                                6'b100101, 6'b100110, 6'b100111};
    logic [3:0] alu_tab [11] = '{4'b1100, 4'b1001, 4'b0001, 4'b1011,
                                 4'b0010, 4'b0011, 4'b1000, 4'b0100,
                                 4'b0101, 4'b0110, 4'b0111};

    multicycle_control #(.n(32), .RETIRE(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluControl(aluControl),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .retired(retired), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] f);
        return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, f};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op);
        return {op, 5'd1, 5'd2, 16'h0004};
    endfunction

    // Zero-wait FETCH then DECODE; returns one cycle after DECODE.
    task automatic fetch_decode(input logic [31:0] ins);
        instr   = ins;
        mem_ack = 1'b1;
        #2;
        tick();
        mem_ack = 1'b0;
        #2;
        tick();
    endtask

    // Runs one instruction from FETCH, acking each memory request after
    // 'delay' wait cycles; stops on return to FETCH, on TRAP, or at 50 cycles.
    task automatic run_instr(input logic [31:0] ins, input int delay, output int cycles);
        int waited;
        cycles = 0;
        waited = 0;
        instr  = ins;
        do begin
            mem_ack = 1'b0;
            if (dbg_state == S_FETCH) begin
                mem_ack = 1'b1;
            end else if (mem_req) begin
                if (waited == delay) mem_ack = 1'b1;
                waited++;
            end
            #2;
            cycles++;
            tick();
        end while (dbg_state != S_FETCH && dbg_state != S_TRAP && cycles < 50);
        mem_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ack = 1'b0;
        tick();
        tick();
        #2;
        checks++;
        if ({mem_req, mem_we, ir_write, pc_write, alu_src_b, aluControl} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b irw=%b pcw=%b srcb=%b alu=%b want all 0",
                     mem_req, mem_we, ir_write, pc_write, alu_src_b, aluControl);
        end
        checks++;
        if (retired !== 16'd0 || illegal !== 1'b0 || dbg_state !== S_FETCH) begin
            errors++;
            $display("FAIL reset_state: got retired=%0d illegal=%b state=%0d want 0 0 FETCH",
                     retired, illegal, dbg_state);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b1 || iord !== 1'b0 || alu_src_b !== 2'b01 || ir_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_fetch: got req=%b iord=%b srcb=%b irw=%b want 1 0 01 0",
                     mem_req, iord, alu_src_b, ir_write);
        end
        tick();
        checks++;
        if (dbg_state !== S_FETCH) begin
            errors++;
            $display("FAIL fetch_wait_no_ack: got state=%0d want FETCH", dbg_state);
        end
    endtask

    task automatic test_reset_memwr();
        fetch_decode(mk_i(6'b101011));
        checks++;
        if (dbg_state !== S_MEMADR) begin
            errors++;
            $display("FAIL sw_memadr: got state=%0d want %0d", dbg_state, S_MEMADR);
        end
        tick();
        #2;
        checks++;
        if (dbg_state !== S_MEMWR || mem_req !== 1'b1 || mem_we !== 1'b1 || iord !== 1'b1) begin
            errors++;
            $display("FAIL sw_memwr: got state=%0d req=%b we=%b iord=%b want MEMWR 1 1 1",
                     dbg_state, mem_req, mem_we, iord);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || retired !== 16'd0 || dbg_state !== S_FETCH) begin
            errors++;
            $display("FAIL memwr_async_reset: got req=%b we=%b retired=%0d state=%0d want 0 0 0 FETCH",
                     mem_req, mem_we, retired, dbg_state);
        end
        mem_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b0;
        tick();
        checks++;
        if (retired !== 16'd0 || dbg_state !== S_FETCH) begin
            errors++;
            $display("FAIL memwr_reset_no_retire: got retired=%0d state=%0d want 0 FETCH",
                     retired, dbg_state);
        end
    endtask

    task automatic test_add();
        instr   = mk_r(6'b100000);
        mem_ack = 1'b1;
        #2;
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'b00 || aluControl !== 4'b0000) begin
            errors++;
            $display("FAIL add_fetch_ack: got irw=%b pcw=%b pcsrc=%b alu=%b want 1 1 00 0000",
                     ir_write, pc_write, pc_src, aluControl);
        end
        tick();
        mem_ack = 1'b0;
        #2;
        checks++;
        if (dbg_state !== S_DECODE || alu_src_b !== 2'b11 || aluControl !== 4'b0000 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL add_decode: got state=%0d srcb=%b alu=%b req=%b want DECODE 11 0000 0",
                     dbg_state, alu_src_b, aluControl, mem_req);
        end
        tick();
        #2;
        checks++;
        if (dbg_state !== S_EXEC || alu_src_a !== 1'b1 || alu_src_b !== 2'b00 ||
            aluControl !== 4'b0000 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: got state=%0d srca=%b srcb=%b alu=%b rw=%b want EXEC 1 00 0000 0",
                     dbg_state, alu_src_a, alu_src_b, aluControl, reg_write);
        end
        tick();
        #2;
        checks++;
        if (dbg_state !== S_ALUWB || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
            errors++;
            $display("FAIL add_aluwb: got state=%0d rw=%b rd=%b m2r=%b want ALUWB 1 1 0",
                     dbg_state, reg_write, reg_dst, mem_to_reg);
        end
        tick();
        exp_retired++;
        checks++;
        if (retired !== exp_retired || dbg_state !== S_FETCH) begin
            errors++;
            $display("FAIL add_retire: got retired=%0d state=%0d want %0d FETCH",
                     retired, dbg_state, exp_retired);
        end
    endtask

    task automatic test_funct();
        for (int i = 0; i < 11; i++) begin
            fetch_decode(mk_r(fn_tab[i]));
            #2;
            checks++;
            if (dbg_state !== S_EXEC || aluControl !== alu_tab[i]) begin
                errors++;
                $display("FAIL funct_%b: got state=%0d alu=%b want EXEC %b",
                         fn_tab[i], dbg_state, aluControl, alu_tab[i]);
            end
            tick();
            tick();
            exp_retired++;
        end
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("FAIL funct_retired: got %0d want %0d", retired, exp_retired);
        end
    endtask

    task automatic test_jr_jump();
        fetch_decode(mk_r(6'b001000));
        #2;
        checks++;
        if (dbg_state !== S_EXEC || aluControl !== 4'b1010 || pc_write !== 1'b1 ||
            pc_src !== 2'b00 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL jr_exec: got state=%0d alu=%b pcw=%b pcsrc=%b rw=%b want EXEC 1010 1 00 0",
                     dbg_state, aluControl, pc_write, pc_src, reg_write);
        end
        tick();
        exp_retired++;
        checks++;
        if (dbg_state !== S_FETCH || retired !== exp_retired) begin
            errors++;
            $display("FAIL jr_retire: got state=%0d retired=%0d want FETCH %0d",
                     dbg_state, retired, exp_retired);
        end
        fetch_decode({6'b000010, 26'h0000040});
        #2;
        checks++;
        if (dbg_state !== S_JUMP || pc_write !== 1'b1 || pc_src !== 2'b10) begin
            errors++;
            $display("FAIL j_jump: got state=%0d pcw=%b pcsrc=%b want JUMP 1 10",
                     dbg_state, pc_write, pc_src);
        end
        tick();
        exp_retired++;
    endtask

    task automatic test_lw_wait();
        int req_cycles;
        instr   = mk_i(6'b100011);
        mem_ack = 1'b1;
        #2;
        tick();
        // ack while no request is outstanding must be ignored
        mem_ack = 1'b1;
        #2;
        tick();
        #2;
        checks++;
        if (dbg_state !== S_MEMADR || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || aluControl !== 4'b0000) begin
            errors++;
            $display("FAIL lw_memadr: got state=%0d srca=%b srcb=%b alu=%b want MEMADR 1 10 0000",
                     dbg_state, alu_src_a, alu_src_b, aluControl);
        end
        tick();
        req_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            mem_ack = (c == 3);
            #2;
            if (mem_req === 1'b1) req_cycles++;
            checks++;
            if (dbg_state !== S_MEMRD || mem_req !== 1'b1 || iord !== 1'b1 || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL lw_memrd_c%0d: got state=%0d req=%b iord=%b rw=%b want MEMRD 1 1 0",
                         c, dbg_state, mem_req, iord, reg_write);
            end
            tick();
        end
        mem_ack = 1'b0;
        #2;
        checks++;
        if (dbg_state !== S_MEMWB || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b1) begin
            errors++;
            $display("FAIL lw_memwb: got state=%0d rw=%b rd=%b m2r=%b want MEMWB 1 0 1",
                     dbg_state, reg_write, reg_dst, mem_to_reg);
        end
        tick();
        exp_retired++;
        checks++;
        if (dbg_state !== S_FETCH || retired !== exp_retired || req_cycles != 4) begin
            errors++;
            $display("FAIL lw_total: got state=%0d retired=%0d req_cycles=%0d want FETCH %0d 4",
                     dbg_state, retired, req_cycles, exp_retired);
        end
    endtask

    task automatic test_beq();
        for (int z = 0; z < 2; z++) begin
            zero    = z[0];
            instr   = {6'b000100, 5'd1, 5'd2, 16'hFFFE};
            mem_ack = 1'b1;
            #2;
            tick();
            mem_ack = 1'b0;
            #2;
            checks++;
            if (dbg_state !== S_DECODE || alu_src_b !== 2'b11 || aluControl !== 4'b0000) begin
                errors++;
                $display("FAIL beq_decode_z%0d: got state=%0d srcb=%b alu=%b want DECODE 11 0000",
                         z, dbg_state, alu_src_b, aluControl);
            end
            tick();
            #2;
            checks++;
            if (dbg_state !== S_BRANCH || alu_src_a !== 1'b1 || alu_src_b !== 2'b00 ||
                aluControl !== 4'b0001 || pc_write_cond !== 1'b1 || pc_src !== 2'b01 || pc_write !== 1'b0) begin
                errors++;
                $display("FAIL beq_branch_z%0d: got state=%0d srca=%b srcb=%b alu=%b pwc=%b pcsrc=%b pcw=%b",
                         z, dbg_state, alu_src_a, alu_src_b, aluControl, pc_write_cond, pc_src, pc_write);
            end
            tick();
            exp_retired++;
        end
        zero = 1'b0;
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("FAIL beq_retired: got %0d want %0d", retired, exp_retired);
        end
    endtask

    task automatic test_cpi();
        logic [31:0] ins_tab [7];
        int          cpi_tab [7];
        int          cyc;
        ins_tab = '{mk_i(6'b101011), mk_i(6'b001000), {6'b000010, 26'h10}, mk_i(6'b100011),
                    mk_r(6'b100101), mk_r(6'b001000), mk_i(6'b000100)};
        cpi_tab = '{4, 4, 3, 5, 4, 3, 3};
        for (int i = 0; i < 7; i++) begin
            run_instr(ins_tab[i], 0, cyc);
            exp_retired++;
            checks++;
            if (cyc != cpi_tab[i] || retired !== exp_retired) begin
                errors++;
                $display("FAIL cpi_%0d: got cycles=%0d retired=%0d want %0d %0d",
                         i, cyc, retired, cpi_tab[i], exp_retired);
            end
        end
        // back-to-back sw with a 2-cycle write wait: 4 + 2
        run_instr(mk_i(6'b101011), 2, cyc);
        exp_retired++;
        checks++;
        if (cyc != 6 || retired !== exp_retired) begin
            errors++;
            $display("FAIL sw_wait2: got cycles=%0d retired=%0d want 6 %0d", cyc, retired, exp_retired);
        end
    endtask

    task automatic test_trap(input logic [31:0] ins, input string name);
        fetch_decode(ins);
        checks++;
        if (dbg_state !== S_TRAP || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_enter: got state=%0d req=%b want TRAP 0", name, dbg_state, mem_req);
        end
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        #2;
        checks++;
        if (illegal !== 1'b1 || dbg_state !== S_TRAP || retired !== exp_retired) begin
            errors++;
            $display("FAIL %s_held: got illegal=%b state=%0d retired=%0d want 1 TRAP %0d",
                     name, illegal, dbg_state, retired, exp_retired);
        end
        rst_n = 1'b0;
        #1;
        exp_retired = '0;
        checks++;
        if (illegal !== 1'b0 || dbg_state !== S_FETCH || retired !== exp_retired) begin
            errors++;
            $display("FAIL %s_reset: got illegal=%b state=%0d retired=%0d want 0 FETCH 0",
                     name, illegal, dbg_state, retired);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_reset_memwr();
        test_add();
        test_funct();
        test_jr_jump();
        test_lw_wait();
        test_beq();
        test_cpi();
        test_trap(32'hFC00_0000, "trap_opcode");
        test_trap(mk_r(6'b111111), "trap_funct");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
